// File: rtl/mm_pkg.sv
// Shared types and helpers for the fixed-point GEMM engine.
// Holds FSM encoding, accumulator sizing and saturation limits.
package mm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    WRITE,
    DONE
  } state_e;

  // Wide enough that K products of 2*dw bits plus a preload never wrap
  function automatic int acc_width(input int dw, input int k);
    return 2 * dw + $clog2(k) + 1;
  endfunction

  function automatic longint sat_max(input int dw);
    return (longint'(1) << (dw - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int dw);
    return -(longint'(1) << (dw - 1));
  endfunction

endpackage

// File: rtl/mm_mac_sat.sv
// Signed MAC with load/accumulate, Q-format rescale and saturation.
// Result and saturation flag are combinational from the accumulator.
module mm_mac_sat
  import mm_pkg::*;
#(
  parameter int DW   = 32,
  parameter int FRAC = 16,
  parameter int K    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          first_i,
  input  logic          acc_mode_i,
  input  logic [DW-1:0] x_i,
  input  logic [DW-1:0] y_i,
  input  logic [DW-1:0] z_i,
  output logic [DW-1:0] result_o,
  output logic          sat_o
);

  localparam int AW = acc_width(DW, K);
  localparam logic signed [AW-1:0] SMAX = AW'(sat_max(DW));
  localparam logic signed [AW-1:0] SMIN = AW'(sat_min(DW));

  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   prod_w;
  logic signed [AW-1:0]   init_w;
  logic signed [AW-1:0]   acc_q;
  logic signed [AW-1:0]   acc_d;
  logic signed [AW-1:0]   shifted;
  logic                   hi;
  logic                   lo;

  assign prod   = $signed(x_i) * $signed(y_i);
  assign prod_w = AW'(prod);
  assign init_w = acc_mode_i ? (AW'($signed(z_i)) <<< FRAC) : '0;

  // First MAC of an element reloads, later ones accumulate
  always_comb begin
    acc_d = acc_q;
    if (en_i) begin
      acc_d = (first_i ? init_w : acc_q) + prod_w;
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end

  assign shifted = acc_q >>> FRAC;
  assign hi      = shifted > SMAX;
  assign lo      = shifted < SMIN;
  assign sat_o   = hi | lo;

  // Clamp to the signed element range
  always_comb begin
    result_o = shifted[DW-1:0];
    if (hi) result_o = SMAX[DW-1:0];
    if (lo) result_o = SMIN[DW-1:0];
  end

endmodule

// File: rtl/matrix_multiplier_fxp.sv
// Fixed-point GEMM sequencer: Z = X*Y (+Z) over external sync RAMs.
// Holds the FSM, index counters and address generation.
module matrix_multiplier_fxp
  import mm_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int FRAC_BITS     = 16,
  parameter int X_ROWS        = 5,
  parameter int X_COLS_Y_ROWS = 5,
  parameter int Y_COLS        = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  accumulate,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH-1:0] x_addr,
  input  logic [DATA_WIDTH-1:0] x_data,
  output logic [ADDR_WIDTH-1:0] y_addr,
  input  logic [DATA_WIDTH-1:0] y_data,
  output logic [ADDR_WIDTH-1:0] z_addr,
  output logic                  z_ren,
  input  logic [DATA_WIDTH-1:0] z_rdata,
  output logic [DATA_WIDTH-1:0] z_wdata,
  output logic                  z_wen
);

  localparam logic [ADDR_WIDTH-1:0] M1 = ADDR_WIDTH'(X_ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] K1 = ADDR_WIDTH'(X_COLS_Y_ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] N1 = ADDR_WIDTH'(Y_COLS - 1);
  localparam logic [ADDR_WIDTH-1:0] KA = ADDR_WIDTH'(X_COLS_Y_ROWS);
  localparam logic [ADDR_WIDTH-1:0] NA = ADDR_WIDTH'(Y_COLS);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   i_q, i_d;
  logic [ADDR_WIDTH-1:0]   j_q, j_d;
  logic [ADDR_WIDTH-1:0]   k_q, k_d;
  logic                    mode_q, mode_d;
  logic                    ovf_q, ovf_d;
  logic                    mac_en_q;
  logic                    mac_first_q;
  logic [ADDR_WIDTH-1:0]   x_addr_q;
  logic [ADDR_WIDTH-1:0]   y_addr_q;
  logic [ADDR_WIDTH-1:0]   z_addr_q;
  logic [ADDR_WIDTH-1:0]   z_cur;
  logic [DATA_WIDTH-1:0]   result;
  logic                    sat;

  assign z_cur    = i_q * NA + j_q;
  assign overflow = ovf_q;

  // Next state, counters and strobes; addresses hold outside use
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    busy    = 1'b0;
    done    = 1'b0;
    z_ren   = 1'b0;
    z_wen   = 1'b0;
    z_wdata = '0;
    x_addr  = x_addr_q;
    y_addr  = y_addr_q;
    z_addr  = z_addr_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = accumulate;
          ovf_d   = 1'b0;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        busy   = 1'b1;
        x_addr = i_q * KA + k_q;
        y_addr = k_q * NA + j_q;
        if (k_q == '0 && mode_q) begin
          z_ren  = 1'b1;
          z_addr = z_cur;
        end
        if (k_q == K1) begin
          k_d     = '0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        busy    = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        busy    = 1'b1;
        z_wen   = 1'b1;
        z_addr  = z_cur;
        z_wdata = result;
        if (sat) ovf_d = 1'b1;
        state_d = FETCH;
        if (j_q == N1) begin
          j_d = '0;
          if (i_q == M1) begin
            i_d     = '0;
            state_d = DONE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, indices and held addresses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      mode_q      <= 1'b0;
      ovf_q       <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_first_q <= 1'b0;
      x_addr_q    <= '0;
      y_addr_q    <= '0;
      z_addr_q    <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      mode_q      <= mode_d;
      ovf_q       <= ovf_d;
      mac_en_q    <= (state_q == FETCH);
      mac_first_q <= (state_q == FETCH) && (k_q == '0);
      x_addr_q    <= x_addr;
      y_addr_q    <= y_addr;
      z_addr_q    <= z_addr;
    end
  end

  mm_mac_sat #(
    .DW   (DATA_WIDTH),
    .FRAC (FRAC_BITS),
    .K    (X_COLS_Y_ROWS)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .en_i       (mac_en_q),
    .first_i    (mac_first_q),
    .acc_mode_i (mode_q),
    .x_i        (x_data),
    .y_i        (y_data),
    .z_i        (z_rdata),
    .result_o   (result),
    .sat_o      (sat)
  );

endmodule

// File: doc/matrix_multiplier_fxp.md
Name: matrix_multiplier_fxp

Overview:
- Parametrised fixed-point GEMM engine: computes Z = X·Y, or Z = X·Y + Z in accumulate mode, over row-major matrices held in external synchronous RAMs.
- Signed Q-format operands; per-element wide accumulator; rounding by truncation; saturating writeback with a sticky overflow flag.
- Sits between the DFR reservoir state RAMs and the output-layer weight RAM; sequenced by the system controller through a start/busy/done handshake.

Parameters:
- ADDR_WIDTH, 32, width of all RAM address ports
- DATA_WIDTH, 32, signed element width for X, Y and Z
- FRAC_BITS, 16, fractional bits of the Q format, shared by X, Y and Z
- X_ROWS, 5, M: rows of X and Z
- X_COLS_Y_ROWS, 5, K: inner dimension; must be ≥ 1
- Y_COLS, 5, N: columns of Y and Z

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- accumulate  in  1  mode select, latched at start: 1 → Z = X·Y + Z
- busy  out  1  high from the cycle after start is accepted until the final write
- done  out  1  one-cycle pulse when the job completes
- overflow  out  1  sticky; set by any saturation; cleared on accepted start
- x_addr  out  ADDR_WIDTH  X read address, i*K + k
- x_data  in  DATA_WIDTH  X read data, valid 1 cycle after address
- y_addr  out  ADDR_WIDTH  Y read address, k*N + j
- y_data  in  DATA_WIDTH  Y read data, valid 1 cycle after address
- z_addr  out  ADDR_WIDTH  Z address for both read and write, i*N + j
- z_ren  out  1  Z read strobe (accumulate mode only)
- z_rdata  in  DATA_WIDTH  Z read data, valid 1 cycle after z_ren
- z_wdata  out  DATA_WIDTH  Z write data
- z_wen  out  1  Z write strobe, one cycle per element

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs are 0; the FSM goes to IDLE; indices and accumulator clear.
  - Reset mid-job aborts the job immediately. No further z_wen occurs, and elements already written are not restored.
- FSM states: IDLE → FETCH → DRAIN → WRITE → (FETCH | DONE) → IDLE.
- IDLE:
  - On start=1: latch accumulate, clear overflow, set i=j=k=0, go to FETCH.
  - busy rises on the next edge.
  - start asserted in any other state is ignored.
- FETCH (K cycles per element):
  - Drive x_addr and y_addr for the current k, then increment k.
  - Each cycle also accumulates the product of the data returned for the previous k.
  - In the first FETCH cycle of an element: if accumulate=1, z_ren=1 with z_addr = i*N+j.
- Accumulator initialisation and update:
  - The first MAC cycle loads acc = (accumulate ? sext(z_rdata) << FRAC_BITS : 0) + x_data*y_data.
  - Every later MAC cycle does acc += x_data*y_data.
  - Product width is 2*DATA_WIDTH signed.
  - Accumulator width is 2*DATA_WIDTH + clog2(K) + 1, so it cannot wrap internally.
- DRAIN (1 cycle): accumulates the product for the last k.
- WRITE (1 cycle):
  - result = acc >>> FRAC_BITS, arithmetic shift (truncation toward −∞).
  - If result exceeds the signed DATA_WIDTH range, saturate to max/min and set overflow.
  - z_wen=1, z_addr = i*N+j, z_wdata = result.
  - Then advance j; when j wraps, advance i. After element (M−1, N−1), go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. A start in this cycle is ignored.
- Latency from start acceptance to the done pulse: M*N*(K+2)+1 cycles. Writes occur in row-major order.
- Address outputs hold their last value when idle. z_ren and z_wen are never high in the same cycle.
- K=1: FETCH lasts 1 cycle, so each element takes 3 cycles.

Decomposition:
- Shared package mm_pkg holds:
  - FSM state enum (IDLE, FETCH, DRAIN, WRITE, DONE)
  - clog2-based ACC_WIDTH function
  - saturation limit constants derived from DATA_WIDTH
- One sub-module, mm_mac_sat, is natural:
  - signed multiply, accumulate with init/load, shift, saturate
  - outputs result and sat flag
- The top level holds the FSM, the index counters and the address generation.

Test Plan:
- Identity: 2×2 defaults with X = I (1.0 = 0x00010000) and Y = [[1.5,2],[−3,0.25]], accumulate=0. Required: Z equals Y exactly, 4 writes in order, done at start+4*(2+2)+1 cycles.
- Fractional truncation, 1×1×1: X = 0x00008000 (0.5), Y = 0xFFFF8000 (−0.5). Required: Z = 0xFFFFC000 (−0.25), overflow=0.
- Saturation: X = Y = 0x7FFF0000, K=2. Required: Z = 0x7FFFFFFF, overflow=1. overflow stays 1 until the next start, then clears.
- Accumulate mode: Z preloaded with 0x00010000 (1.0), X = Y = I. Required:
  - diagonal elements = 0x00020000, off-diagonal = 0x00010000
  - z_ren pulses once per element, one cycle before the first MAC.
- Start while busy: pulse start mid-job. Required: ignored, with no restart, unchanged latency and unchanged write count.
- Reset mid-job: drive rst=0 during the third element's FETCH. Required: all outputs go to 0 asynchronously with no further z_wen. A new start after release completes a full, correct job.
